// File: rtl/led_bank_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : led_bank_arbiter
// Purpose  : Shares the 8-LED bank (D2..D9) between two requesters. Each
//            requester hands over an 8-bit pattern and a hold time through a
//            valid/ready handshake. The granted pattern is displayed for the
//            hold time, and then the arbiter re-arbitrates. With no request
//            pending, a rotating single-LED idle pattern is displayed.
// Ports    : clk            system clock
//            rstn           asynchronous reset, active low
//            reqN_valid     requester N has a pattern to show
//            reqN_ready     requester N transfer accepted this cycle
//            reqN_pattern   pattern, bit0 -> D2 ... bit7 -> D9
//            reqN_ticks     hold time in ticks (0 is treated as 1)
//            leds           registered LED drive, 1 = on
//            busy           a requester pattern is being displayed
//            owner          requester being displayed (meaningful when busy)
// Config   : LED_ARB_PRIO_EN  fixed priority for req0, which may also preempt
//                             a display owned by req1
// Revision : 1.0  initial release
// ============================================================================
module led_bank_arbiter #(
  parameter int TICK_DIV   = 12000,  // clk cycles per tick, 2..2^24
  parameter int IDLE_TICKS = 100     // ticks per idle rotation step, 1..2^16
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [7:0] req0_pattern,
  input  logic [7:0] req0_ticks,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [7:0] req1_pattern,
  input  logic [7:0] req1_ticks,
  output logic [7:0] leds,
  output logic       busy,
  output logic       owner
);

  localparam logic [23:0] C_TICK_LAST = 24'(TICK_DIV - 1);
  localparam logic [15:0] C_IDLE_LAST = 16'(IDLE_TICKS - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SHOW = 1'b1
  } state_t;

  state_t      state_q,      state_d;
  logic [23:0] presc_q,      presc_d;
  logic [15:0] idle_cnt_q,   idle_cnt_d;
  logic [7:0]  idle_pat_q,   idle_pat_d;
  logic [7:0]  hold_q,       hold_d;
  logic [7:0]  pattern_q,    pattern_d;
  logic [7:0]  leds_q,       leds_d;
  logic        owner_q,      owner_d;
  logic        last_grant_q, last_grant_d;

  logic       tick;
  logic       grant0;
  logic       grant1;
  logic       accept;
  logic [7:0] acc_pattern;
  logic [7:0] acc_ticks;

  // Free-running tick prescaler; accepts never restart it, which is why the
  // display time of a request has one tick period of uncertainty.
  always_comb begin
    tick    = (presc_q == C_TICK_LAST);
    presc_d = tick ? 24'd0 : presc_q + 24'd1;
  end

  // Arbitration. Grants are combinational so that ready goes high in the
  // same cycle as the winning valid.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
`ifdef LED_ARB_PRIO_EN
    if (state_q == ST_IDLE) begin
      grant0 = req0_valid;
      grant1 = req1_valid & ~req0_valid;
    end else begin
      // req0 may take over a display owned by req1, never its own
      grant0 = req0_valid & owner_q;
    end
`else
    if (state_q == ST_IDLE) begin
      if (req0_valid && req1_valid) begin
        // tie goes to the requester that was not granted last
        grant0 = last_grant_q;
        grant1 = ~last_grant_q;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
`endif
    accept      = grant0 | grant1;
    acc_pattern = grant1 ? req1_pattern : req0_pattern;
    acc_ticks   = grant1 ? req1_ticks   : req0_ticks;
  end

  // Next-state logic.
  always_comb begin
    state_d      = state_q;
    idle_cnt_d   = idle_cnt_q;
    idle_pat_d   = idle_pat_q;
    hold_d       = hold_q;
    pattern_d    = pattern_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;

    // The idle pattern only advances while it is actually being shown.
    if (state_q == ST_IDLE && !accept && tick) begin
      if (idle_cnt_q == C_IDLE_LAST) begin
        idle_cnt_d = 16'd0;
        idle_pat_d = {idle_pat_q[6:0], idle_pat_q[7]};
      end else begin
        idle_cnt_d = idle_cnt_q + 16'd1;
      end
    end

    if (accept) begin
      state_d      = ST_SHOW;
      pattern_d    = acc_pattern;
      hold_d       = (acc_ticks == 8'd0) ? 8'd1 : acc_ticks;
      owner_d      = grant1;
      last_grant_d = grant1;
    end else if (state_q == ST_SHOW && tick) begin
      if (hold_q <= 8'd1) begin
        state_d = ST_IDLE;
      end else begin
        hold_d = hold_q - 8'd1;
      end
    end

    leds_d = (state_d == ST_SHOW) ? pattern_d : idle_pat_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      presc_q      <= 24'd0;
      idle_cnt_q   <= 16'd0;
      idle_pat_q   <= 8'h01;
      hold_q       <= 8'd0;
      pattern_q    <= 8'h00;
      leds_q       <= 8'h00;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;  // makes req0 win the first tie
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      idle_cnt_q   <= idle_cnt_d;
      idle_pat_q   <= idle_pat_d;
      hold_q       <= hold_d;
      pattern_q    <= pattern_d;
      leds_q       <= leds_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign leds       = leds_q;
  assign busy       = (state_q == ST_SHOW);
  assign owner      = owner_q;

endmodule
`default_nettype wire

// File: tb/tb_led_bank_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_led_bank_arbiter
// Purpose  : Self-checking bench for led_bank_arbiter (TICK_DIV=4,
//            IDLE_TICKS=2). Stimulus pushes expected grants into a queue; a
//            monitor pops them on every observed ready and follows the
//            resulting display (pattern, owner, duration, idle gap).
// Config   : honours LED_ARB_PRIO_EN for the priority/preemption expectations
// Revision : 1.0  initial release
// ============================================================================
module tb_led_bank_arbiter;

  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       req0_valid = 1'b0;
  logic       req0_ready;
  logic [7:0] req0_pattern = 8'h00;
  logic [7:0] req0_ticks = 8'h00;
  logic       req1_valid = 1'b0;
  logic       req1_ready;
  logic [7:0] req1_pattern = 8'h00;
  logic [7:0] req1_ticks = 8'h00;
  logic [7:0] leds;
  logic       busy;
  logic       owner;

  always #5 clk = ~clk;

  led_bank_arbiter #(.TICK_DIV(TD), .IDLE_TICKS(2)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .req0_valid   (req0_valid),
    .req0_ready   (req0_ready),
    .req0_pattern (req0_pattern),
    .req0_ticks   (req0_ticks),
    .req1_valid   (req1_valid),
    .req1_ready   (req1_ready),
    .req1_pattern (req1_pattern),
    .req1_ticks   (req1_ticks),
    .leds         (leds),
    .busy         (busy),
    .owner        (owner)
  );

  typedef struct {
    bit       id;
    logic [7:0] pat;
    int       h;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   grants   = 0;
  bit   showing  = 1'b0;
  int   dur      = 0;
  exp_t cur;
  logic [7:0] pre_leds = 8'h00;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  task automatic chk_true(input string n, input bit ok, input int a, input int e);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", n, a, e);
    end
  endtask

  function automatic logic [7:0] rotl(input logic [7:0] v);
    return {v[6:0], v[7]};
  endfunction

  // Monitor / scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        showing = 1'b0;
        continue;
      end
      if (showing) begin
        if (busy) begin
          dur++;
          chk("show_leds", leds, cur.pat);
          chk("show_owner", owner, cur.id);
          if (dur > cur.h * TD) begin
            chk_true("show_too_long", 1'b0, dur, cur.h * TD);
            showing = 1'b0;
          end
        end else begin
          chk_true("show_duration",
                   dur >= (cur.h - 1) * TD + 1 && dur <= cur.h * TD,
                   dur, cur.h * TD);
          chk_true("idle_after_show",
                   leds == pre_leds || leds == rotl(pre_leds),
                   leds, pre_leds);
          showing = 1'b0;
        end
      end
      if (req0_ready || req1_ready) begin
        chk("ready_onehot", req0_ready & req1_ready, 1'b0);
        if (showing) begin
`ifdef LED_ARB_PRIO_EN
          chk_true("preempt_legal", req0_ready && cur.id == 1'b1, req0_ready, 1);
`else
          chk_true("ready_in_show", 1'b0, 1, 0);
`endif
        end
        if (sb.size() == 0) begin
          chk_true("unexpected_grant", 1'b0, req1_ready, 0);
        end else begin
          e = sb.pop_front();
          chk("grant_id", req1_ready, e.id);
          cur = e;
          if (!showing) pre_leds = leds;
          showing = 1'b1;
          dur = 0;
          grants++;
        end
      end
    end
  end

  task automatic push_exp(input bit id, input logic [7:0] pat, input logic [7:0] t);
    exp_t e;
    e.id  = id;
    e.pat = pat;
    e.h   = (t == 8'd0) ? 1 : int'(t);
    sb.push_back(e);
  endtask

  task automatic drive(input bit id, input bit v, input logic [7:0] pat, input logic [7:0] t);
    if (id) begin
      req1_valid = v; req1_pattern = pat; req1_ticks = t;
    end else begin
      req0_valid = v; req0_pattern = pat; req0_ticks = t;
    end
  endtask

  // Returns right after the accepting posedge once grants reaches target.
  task automatic wait_grants(input string n, input int target);
    int i = 0;
    do begin
      @(posedge clk);
      i++;
    end while (grants < target && i < 200);
    if (grants < target) chk_true(n, 1'b0, grants, target);
    #1;
  endtask

  task automatic send(input bit id, input logic [7:0] pat, input logic [7:0] t);
    int g0;
    g0 = grants;
    push_exp(id, pat, t);
    @(posedge clk); #1;
    drive(id, 1'b1, pat, t);
    wait_grants("send_timeout", g0 + 1);
    drive(id, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (!showing && !busy && sb.size() == 0) done = 1'b1;
    end
    if (!done) chk_true("idle_timeout", 1'b0, sb.size(), 0);
  endtask

  initial begin
    int g0;
    // Test 1: reset values and idle rotation
    repeat (3) @(negedge clk);
    chk("rst_leds", leds, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_owner", owner, 1'b0);
    rstn = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      chk("idle_rot", leds, 8'h01 << (k / 8));
      chk("idle_busy", busy, 1'b0);
    end

    // Test 2: single request from req0
    send(1'b0, 8'hA5, 8'd3);
    wait_idle();

    // Test 4: ticks=0 from req1 (leaves last_grant=1)
    send(1'b1, 8'h5A, 8'd0);
    wait_idle();

    // Test 3: both held, round-robin alternation (fixed priority with macro)
    g0 = grants;
`ifdef LED_ARB_PRIO_EN
    push_exp(1'b0, 8'h0F, 8'd1); push_exp(1'b0, 8'h0F, 8'd1);
    push_exp(1'b0, 8'h0F, 8'd1); push_exp(1'b0, 8'h0F, 8'd1);
`else
    push_exp(1'b0, 8'h0F, 8'd1); push_exp(1'b1, 8'hF0, 8'd1);
    push_exp(1'b0, 8'h0F, 8'd1); push_exp(1'b1, 8'hF0, 8'd1);
`endif
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 8'h0F, 8'd1);
    drive(1'b1, 1'b1, 8'hF0, 8'd1);
    wait_grants("alt_timeout", g0 + 4);
    drive(1'b0, 1'b0, 8'h00, 8'h00);
    drive(1'b1, 1'b0, 8'h00, 8'h00);
    wait_idle();

    // Test 5: reset during a display
    send(1'b0, 8'hFF, 8'd10);
    repeat (3) @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("async_rst_leds", leds, 8'h00);
    chk("async_rst_busy", busy, 1'b0);
    chk("async_rst_owner", owner, 1'b0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("post_rst_leds", leds, 8'h01);
    chk("post_rst_busy", busy, 1'b0);

    // Test 6: req0 arrives while req1 is displayed
    send(1'b1, 8'h3C, 8'd10);
    repeat (5) @(posedge clk);
    #1;
    g0 = grants;
    push_exp(1'b0, 8'hC3, 8'd1);
    drive(1'b0, 1'b1, 8'hC3, 8'd1);
`ifdef LED_ARB_PRIO_EN
    @(negedge clk);
    chk("preempt_ready", req0_ready, 1'b1);
    wait_grants("preempt_timeout", g0 + 1);
    @(negedge clk);
    chk("preempt_leds", leds, 8'hC3);
    chk("preempt_owner", owner, 1'b0);
    drive(1'b0, 1'b0, 8'h00, 8'h00);
`else
    repeat (3) begin
      @(negedge clk);
      chk("no_preempt_ready", req0_ready, 1'b0);
      chk("no_preempt_owner", owner, 1'b1);
    end
    wait_grants("after_req1_timeout", g0 + 1);
    drive(1'b0, 1'b0, 8'h00, 8'h00);
`endif
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
